// File: rtl/fpu_dec.sv
// Operand decoder for the FPU: unpacks two IEEE-754 words into sign, signed
// unbiased exponent, hidden-bit significand and one-hot class.
module fpu_dec #(
  parameter int OPERAND_WIDTH = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1,
  parameter logic [EXPONENT_WIDTH-1:0] BIASING_CONSTANT = 8'b0111_1111
) (
  input  logic                         fpu_clk,
  input  logic                         fpu_rst,
  input  logic                         fpu_dec_en_i,
  input  logic [OPERAND_WIDTH-1:0]     fpu_opa_i,
  input  logic [OPERAND_WIDTH-1:0]     fpu_opb_i,
  output logic                         fpu_dec_ready_o,
  output logic                         fpu_dec_a_sign_o,
  output logic                         fpu_dec_b_sign_o,
  output logic [EXPONENT_WIDTH:0]      fpu_dec_a_exp_o,
  output logic [EXPONENT_WIDTH:0]      fpu_dec_b_exp_o,
  output logic [SIGNIFICAND_WIDTH-1:0] fpu_dec_a_sig_o,
  output logic [SIGNIFICAND_WIDTH-1:0] fpu_dec_b_sig_o,
  output logic [4:0]                   fpu_dec_a_type_o,
  output logic [4:0]                   fpu_dec_b_type_o,
  output logic                         fpu_dec_a_snan_o,
  output logic                         fpu_dec_b_snan_o,
  output logic                         fpu_dec_a_sub_o,
  output logic                         fpu_dec_b_sub_o
);

  localparam int XW = EXPONENT_WIDTH + 1;
  localparam int SMSB = SIGNIFICAND_WIDTH - 1;

  localparam logic [4:0] TYPE_NAN  = 5'b10000;
  localparam logic [4:0] TYPE_PINF = 5'b01000;
  localparam logic [4:0] TYPE_NINF = 5'b00100;
  localparam logic [4:0] TYPE_ZERO = 5'b00010;
  localparam logic [4:0] TYPE_FIN  = 5'b00001;

  localparam logic [EXPONENT_WIDTH-1:0] EXP_FIELD_ZERO = {EXPONENT_WIDTH{1'b0}};
  localparam logic [EXPONENT_WIDTH-1:0] EXP_FIELD_MAX  = {EXPONENT_WIDTH{1'b1}};
  localparam logic [FRACTION_WIDTH-1:0] FRAC_ZERO      = {FRACTION_WIDTH{1'b0}};
  localparam logic [XW-1:0] EXP_ONE     = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] EXP_SUB     = EXP_ONE - {1'b0, BIASING_CONSTANT};
  localparam logic [XW-1:0] EXP_SPECIAL = {1'b0, EXP_FIELD_MAX} - {1'b0, BIASING_CONSTANT};

  typedef struct packed {
    logic                         sign;
    logic [XW-1:0]                exp;
    logic [SIGNIFICAND_WIDTH-1:0] sig;
    logic [4:0]                   typ;
    logic                         snan;
    logic                         sub;
  } opnd_t;

  localparam int OPND_W = $bits(opnd_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLASS = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic opnd_t decode_op(input logic [OPERAND_WIDTH-1:0] word);
    logic [EXPONENT_WIDTH-1:0] e;
    logic [FRACTION_WIDTH-1:0] f;
    opnd_t d;
    e = word[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
    f = word[FRACTION_WIDTH-1:0];
    d = {OPND_W{1'b0}};
    d.sign = word[OPERAND_WIDTH-1];
    if (e == EXP_FIELD_ZERO) begin
      if (f == FRAC_ZERO) begin
        d.typ = TYPE_ZERO;
      end else begin
        d.typ = TYPE_FIN;
        d.sub = 1'b1;
        d.exp = EXP_SUB;
        d.sig = {1'b0, f};
      end
    end else if (e == EXP_FIELD_MAX) begin
      d.exp = EXP_SPECIAL;
      if (f == FRAC_ZERO) begin
        d.typ = word[OPERAND_WIDTH-1] ? TYPE_NINF : TYPE_PINF;
      end else begin
        d.typ  = TYPE_NAN;
        d.sig  = {1'b0, f};
        d.snan = ~f[FRACTION_WIDTH-1];
      end
    end else begin
      d.typ = TYPE_FIN;
      d.exp = {1'b0, e} - {1'b0, BIASING_CONSTANT};
      d.sig = {1'b1, f};
    end
    return d;
  endfunction

  // Only subnormals still lacking a leading one move; everything else holds.
  function automatic opnd_t norm_step(input opnd_t d);
    opnd_t r;
    r = d;
    if (d.sub && !d.sig[SMSB]) begin
      r.sig = {d.sig[SMSB-1:0], 1'b0};
      r.exp = d.exp - EXP_ONE;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic is_normalised(input opnd_t d);
    return !d.sub || d.sig[SMSB];
  endfunction

  state_t                   state_r, state_s;
  logic [OPERAND_WIDTH-1:0] raw_a_r, raw_a_s, raw_b_r, raw_b_s;
  opnd_t                    work_a_r, work_a_s, work_b_r, work_b_s;
  opnd_t                    out_a_r, out_a_s, out_b_r, out_b_s;
  logic                     ready_r, ready_s;

  // Next-state, operand capture, decode/normalise and output load.
  always_comb begin
    state_s  = state_r;
    raw_a_s  = raw_a_r;
    raw_b_s  = raw_b_r;
    work_a_s = work_a_r;
    work_b_s = work_b_r;
    out_a_s  = out_a_r;
    out_b_s  = out_b_r;
    case (state_r)
      IDLE: begin
        if (fpu_dec_en_i) begin
          raw_a_s = fpu_opa_i;
          raw_b_s = fpu_opb_i;
          state_s = CLASS;
        end else begin
          state_s = IDLE;
        end
      end
      CLASS: begin
        if (!fpu_dec_en_i) begin
          state_s = IDLE;
        end else begin
          work_a_s = decode_op(raw_a_r);
          work_b_s = decode_op(raw_b_r);
          if (work_a_s.sub || work_b_s.sub) begin
            state_s = NORM;
          end else begin
            state_s = DONE;
            out_a_s = work_a_s;
            out_b_s = work_b_s;
          end
        end
      end
      NORM: begin
        if (!fpu_dec_en_i) begin
          state_s = IDLE;
        end else begin
          work_a_s = norm_step(work_a_r);
          work_b_s = norm_step(work_b_r);
          if (is_normalised(work_a_s) && is_normalised(work_b_s)) begin
            state_s = DONE;
            out_a_s = work_a_s;
            out_b_s = work_b_s;
          end else begin
            state_s = NORM;
          end
        end
      end
      DONE: begin
        if (!fpu_dec_en_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = (state_s == DONE);
  end

  // State, working and output registers; reset clears everything.
  always_ff @(posedge fpu_clk) begin
    if (fpu_rst) begin
      state_r  <= IDLE;
      raw_a_r  <= {OPERAND_WIDTH{1'b0}};
      raw_b_r  <= {OPERAND_WIDTH{1'b0}};
      work_a_r <= {OPND_W{1'b0}};
      work_b_r <= {OPND_W{1'b0}};
      out_a_r  <= {OPND_W{1'b0}};
      out_b_r  <= {OPND_W{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      raw_a_r  <= raw_a_s;
      raw_b_r  <= raw_b_s;
      work_a_r <= work_a_s;
      work_b_r <= work_b_s;
      out_a_r  <= out_a_s;
      out_b_r  <= out_b_s;
      ready_r  <= ready_s;
    end
  end

  assign fpu_dec_ready_o  = ready_r;
  assign fpu_dec_a_sign_o = out_a_r.sign;
  assign fpu_dec_b_sign_o = out_b_r.sign;
  assign fpu_dec_a_exp_o  = out_a_r.exp;
  assign fpu_dec_b_exp_o  = out_b_r.exp;
  assign fpu_dec_a_sig_o  = out_a_r.sig;
  assign fpu_dec_b_sig_o  = out_b_r.sig;
  assign fpu_dec_a_type_o = out_a_r.typ;
  assign fpu_dec_b_type_o = out_b_r.typ;
  assign fpu_dec_a_snan_o = out_a_r.snan;
  assign fpu_dec_b_snan_o = out_b_r.snan;
  assign fpu_dec_a_sub_o  = out_a_r.sub;
  assign fpu_dec_b_sub_o  = out_b_r.sub;

endmodule

// File: tb/tb_fpu_dec.sv
// Bench for fpu_dec: directed cases plus random requests, checked every
// cycle against a behavioural decode/latency model.
module tb_fpu_dec;

  logic        fpu_clk, fpu_rst, fpu_dec_en_i;
  logic [31:0] fpu_opa_i, fpu_opb_i;
  logic        fpu_dec_ready_o;
  logic        a_sign, b_sign, a_snan, b_snan, a_sub, b_sub;
  logic [8:0]  a_exp, b_exp;
  logic [23:0] a_sig, b_sig;
  logic [4:0]  a_type, b_type;

  fpu_dec dut (
    .fpu_clk(fpu_clk), .fpu_rst(fpu_rst), .fpu_dec_en_i(fpu_dec_en_i),
    .fpu_opa_i(fpu_opa_i), .fpu_opb_i(fpu_opb_i), .fpu_dec_ready_o(fpu_dec_ready_o),
    .fpu_dec_a_sign_o(a_sign), .fpu_dec_b_sign_o(b_sign),
    .fpu_dec_a_exp_o(a_exp), .fpu_dec_b_exp_o(b_exp),
    .fpu_dec_a_sig_o(a_sig), .fpu_dec_b_sig_o(b_sig),
    .fpu_dec_a_type_o(a_type), .fpu_dec_b_type_o(b_type),
    .fpu_dec_a_snan_o(a_snan), .fpu_dec_b_snan_o(b_snan),
    .fpu_dec_a_sub_o(a_sub), .fpu_dec_b_sub_o(b_sub)
  );

  initial fpu_clk = 1'b0;
  always #5 fpu_clk = ~fpu_clk;

  typedef struct packed {
    logic       sign;
    logic [8:0] exp;
    logic [23:0] sig;
    logic [4:0] typ;
    logic       snan;
    logic       sub;
    int         k;
  } dec_t;

  int   n_cmp = 0, n_bad = 0;
  int   edge_no = 0;
  bit   chk_on = 1'b0;
  int   m_phase = 0, m_cnt = 0, m_lat = 0;
  bit   m_ready = 1'b0;
  dec_t ma, mb;
  int   acc_edge = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  // Reference decode from the IEEE field rules, using plain arithmetic.
  function automatic dec_t model_dec(input logic [31:0] w);
    dec_t d;
    int e, ex, p;
    logic [22:0] f;
    logic [23:0] t;
    e = int'(w[30:23]);
    f = w[22:0];
    d.sign = w[31]; d.snan = 1'b0; d.sub = 1'b0; d.k = 0; d.sig = 24'h0; ex = 0;
    if (e == 0 && f == 23'h0) begin
      d.typ = 5'b00010;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      d.k = 23 - p;
      t = {1'b0, f};
      d.sig = t << d.k;
      ex = -126 - d.k;
      d.sub = 1'b1;
      d.typ = 5'b00001;
    end else if (e == 255) begin
      ex = 128;
      if (f == 23'h0) begin
        d.typ = w[31] ? 5'b00100 : 5'b01000;
      end else begin
        d.typ = 5'b10000;
        d.sig = {1'b0, f};
        d.snan = ~f[22];
      end
    end else begin
      ex = e - 127;
      d.sig = {1'b1, f};
      d.typ = 5'b00001;
    end
    d.exp = ex[8:0];
    return d;
  endfunction

  // Protocol model: accept, count 1+k edges, hold while en, drop on !en.
  initial begin
    forever begin
      @(posedge fpu_clk);
      edge_no++;
      if (fpu_rst) begin
        m_phase = 0; m_ready = 1'b0;
      end else if (m_phase == 0) begin
        if (fpu_dec_en_i) begin
          ma = model_dec(fpu_opa_i);
          mb = model_dec(fpu_opb_i);
          m_lat = 1 + ((ma.k > mb.k) ? ma.k : mb.k);
          m_cnt = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!fpu_dec_en_i) m_phase = 0;
        else begin
          m_cnt++;
          if (m_cnt == m_lat) begin m_phase = 2; m_ready = 1'b1; end
        end
      end else begin
        if (!fpu_dec_en_i) begin m_phase = 0; m_ready = 1'b0; end
      end
    end
  end

  // Per-cycle comparison of ready and, while valid, every decoded field.
  initial begin
    forever begin
      @(negedge fpu_clk);
      if (chk_on) begin
        chk("ready", 64'(fpu_dec_ready_o), 64'(m_ready));
        if (m_ready && fpu_dec_ready_o) begin
          chk("a_sign", 64'(a_sign), 64'(ma.sign));
          chk("a_exp",  64'(a_exp),  64'(ma.exp));
          chk("a_sig",  64'(a_sig),  64'(ma.sig));
          chk("a_type", 64'(a_type), 64'(ma.typ));
          chk("a_snan", 64'(a_snan), 64'(ma.snan));
          chk("a_sub",  64'(a_sub),  64'(ma.sub));
          chk("b_sign", 64'(b_sign), 64'(mb.sign));
          chk("b_exp",  64'(b_exp),  64'(mb.exp));
          chk("b_sig",  64'(b_sig),  64'(mb.sig));
          chk("b_type", 64'(b_type), 64'(mb.typ));
          chk("b_snan", 64'(b_snan), 64'(mb.snan));
          chk("b_sub",  64'(b_sub),  64'(mb.sub));
        end
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge fpu_clk);
    fpu_dec_en_i = 1'b1; fpu_opa_i = a; fpu_opb_i = b;
    acc_edge = edge_no + 1;
  endtask

  task automatic wait_ready(output int lat);
    int n;
    n = 0;
    while (!fpu_dec_ready_o && n < 40) begin
      @(negedge fpu_clk);
      n++;
    end
    if (!fpu_dec_ready_o) chk("ready_timeout", 64'(fpu_dec_ready_o), 64'd1);
    lat = edge_no - acc_edge;
  endtask

  task automatic release_en();
    fpu_dec_en_i = 1'b0;
    @(negedge fpu_clk);
  endtask

  function automatic logic [31:0] rand_op();
    logic [22:0] f;
    logic [31:0] w;
    int cls;
    cls = $urandom_range(0, 5);
    f = 23'($urandom());
    w = 32'($urandom());
    case (cls)
      0: w = {w[31], 31'h0};
      1: begin
        f = f >> $urandom_range(0, 22);
        if (f == 23'h0) f = 23'h1;
        w = {w[31], 8'h00, f};
      end
      4: w = {w[31], 8'hFF, 23'h0};
      5: begin
        if (f == 23'h0) f = 23'h1;
        w = {w[31], 8'hFF, f};
      end
      default: w = {w[31], 8'($urandom_range(1, 254)), f};
    endcase
    return w;
  endfunction

  int lat, seen;
  bit aborted;

  initial begin
    fpu_rst = 1'b1; fpu_dec_en_i = 1'b0; fpu_opa_i = 32'h0; fpu_opb_i = 32'h0;
    repeat (3) @(negedge fpu_clk);
    chk("rst_ready", 64'(fpu_dec_ready_o), 64'd0);
    chk("rst_a_outs", 64'({a_sign, a_exp, a_sig, a_type, a_snan, a_sub}), 64'd0);
    chk("rst_b_outs", 64'({b_sign, b_exp, b_sig, b_type, b_snan, b_sub}), 64'd0);
    fpu_rst = 1'b0;
    chk_on = 1'b1;

    // Normal pair, latency 1.
    start(32'h3F800000, 32'hC0200000);
    wait_ready(lat);
    chk("normal_lat", 64'(lat), 64'd1);
    chk("normal_a", 64'({a_sign, a_exp, a_sig, a_type}), {23'h0, 1'b0, 9'h000, 24'h800000, 5'b00001});
    chk("normal_b", 64'({b_sign, b_exp, b_sig, b_type}), {23'h0, 1'b1, 9'h001, 24'hA00000, 5'b00001});
    release_en();

    // Subnormal pair, worst-case latency, operands changed while busy.
    start(32'h00000001, 32'h00400000);
    repeat (5) @(negedge fpu_clk);
    fpu_opa_i = 32'h12345678; fpu_opb_i = 32'hFFFFFFFF;
    wait_ready(lat);
    chk("sub_lat", 64'(lat), 64'd24);
    chk("sub_a", 64'({a_exp, a_sig, a_sub}), {30'h0, 9'h16B, 24'h800000, 1'b1});
    chk("sub_b", 64'({b_exp, b_sig, b_sub}), {30'h0, 9'h181, 24'h800000, 1'b1});
    release_en();

    // Specials: infinities, NaNs, negative zero.
    start(32'h7F800000, 32'hFF800000);
    wait_ready(lat);
    chk("inf_a", 64'({a_type, a_exp, a_sig}), {26'h0, 5'b01000, 9'h080, 24'h0});
    chk("inf_b", 64'({b_sign, b_type}), {58'h0, 1'b1, 5'b00100});
    release_en();
    start(32'h7FC00000, 32'h7F800001);
    wait_ready(lat);
    chk("qnan_a", 64'({a_type, a_snan}), {58'h0, 5'b10000, 1'b0});
    chk("snan_b", 64'({b_type, b_snan}), {58'h0, 5'b10000, 1'b1});
    release_en();
    start(32'h80000000, 32'h3F800000);
    wait_ready(lat);
    chk("nzero_a", 64'({a_sign, a_type, a_exp, a_sig}), {25'h0, 1'b1, 5'b00010, 9'h0, 24'h0});

    // Handshake: hold 5 cycles, drop, re-raise the following cycle.
    repeat (5) @(negedge fpu_clk);
    chk("hold_ready", 64'(fpu_dec_ready_o), 64'd1);
    release_en();
    chk("drop_ready", 64'(fpu_dec_ready_o), 64'd0);
    start(32'h00000100, 32'h40490FDB);
    wait_ready(lat);
    chk("rereq_lat", 64'(lat), 64'd16);

    // Reset mid-normalisation clears all outputs.
    release_en();
    start(32'h00000001, 32'h3F800000);
    while (edge_no < acc_edge + 9) @(negedge fpu_clk);
    fpu_rst = 1'b1;
    @(negedge fpu_clk);
    chk("midrst_ready", 64'(fpu_dec_ready_o), 64'd0);
    chk("midrst_a", 64'({a_sign, a_exp, a_sig, a_type, a_snan, a_sub}), 64'd0);
    chk("midrst_b", 64'({b_sign, b_exp, b_sig, b_type, b_snan, b_sub}), 64'd0);
    fpu_rst = 1'b0; fpu_dec_en_i = 1'b0;
    @(negedge fpu_clk);

    // Abort in NORM: ready must never rise.
    start(32'h00000001, 32'h00000000);
    repeat (5) @(negedge fpu_clk);
    fpu_dec_en_i = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge fpu_clk);
      if (fpu_dec_ready_o) seen++;
    end
    chk("abort_no_ready", 64'(seen), 64'd0);

    // Random requests with random holds, gaps and aborts.
    for (int t = 0; t < 150; t++) begin
      start(rand_op(), rand_op());
      aborted = 1'b0;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge fpu_clk);
        if (fpu_dec_ready_o) begin seen = 1; break; end
        if ($urandom_range(0, 15) == 0) begin
          fpu_dec_en_i = 1'b0; aborted = 1'b1; break;
        end
        if (n == 10) begin fpu_opa_i = $urandom(); fpu_opb_i = $urandom(); end
      end
      if (!aborted) begin
        if (seen == 0) chk("rand_timeout", 64'(fpu_dec_ready_o), 64'd1);
        repeat ($urandom_range(0, 4)) @(negedge fpu_clk);
      end
      release_en();
      repeat ($urandom_range(0, 2)) @(negedge fpu_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
